// File: rtl/branch_predictor_if.sv
// Fetch/execute port bundle of the branch predictor.
// Fetch: lookup_pc in; predict_taken/predict_target/pc_next out.
// Execute: upd_* and clear in; mispredict_cnt out.
interface branch_predictor_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      lookup_pc;
  logic             predict_taken;
  logic [31:0]      predict_target;
  logic [31:0]      pc_next;
  logic             upd_en;
  logic [31:0]      upd_pc;
  logic             upd_taken;
  logic [31:0]      upd_target;
  logic             upd_pred_taken;
  logic [31:0]      upd_pred_target;
  logic             clear;
  logic [CNT_W-1:0] mispredict_cnt;

  modport master (
    output lookup_pc,
    input  predict_taken, predict_target,
    input  pc_next,
    output upd_en, upd_pc, upd_taken,
    output upd_target, upd_pred_taken,
    output upd_pred_target, clear,
    input  mispredict_cnt
  );

  modport slave (
    input  lookup_pc,
    output predict_taken, predict_target,
    output pc_next,
    input  upd_en, upd_pc, upd_taken,
    input  upd_target, upd_pred_taken,
    input  upd_pred_target, clear,
    output mispredict_cnt
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with saturating direction counters.
// Ports: CLK, nRST (async low), bp (slave side of branch_predictor_if).
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  parameter int CNT_W   = 16
) (
  input logic CLK,
  input logic nRST,
  branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [TAG_W-1:0] tag_t;
  typedef logic [CTR_W-1:0] ctr_t;

  localparam ctr_t CMAX = '1;
  // WT = MSB only, WN = all ones below MSB
  localparam ctr_t WN = CMAX >> 1;
  localparam ctr_t WT = CMAX ^ WN;

  logic [ENTRIES-1:0] valid_q;
  tag_t               tag_q [ENTRIES];
  logic [31:0]        tgt_q [ENTRIES];
  ctr_t               ctr_q [ENTRIES];
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  idx_t        l_idx;
  tag_t        l_tag;
  logic        l_hit;
  logic        l_taken;
  logic [31:0] l_tgt;

  assign l_idx = bp.lookup_pc[IDX_W+1:2];
  assign l_tag = bp.lookup_pc[31:IDX_W+2];

  always_comb begin
    l_hit   = valid_q[l_idx]
            && (tag_q[l_idx] == l_tag);
    l_taken = l_hit && ctr_q[l_idx][CTR_W-1];
    l_tgt   = valid_q[l_idx] ? tgt_q[l_idx]
                             : 32'd0;
  end

  assign bp.predict_taken  = l_taken;
  assign bp.predict_target = l_tgt;
  assign bp.pc_next = l_taken ? l_tgt
                    : bp.lookup_pc + 32'd4;

  idx_t u_idx;
  tag_t u_tag;
  logic u_hit;
  ctr_t u_ctr, u_inc, u_dec;
  logic mispred;

  assign u_idx = bp.upd_pc[IDX_W+1:2];
  assign u_tag = bp.upd_pc[31:IDX_W+2];

  always_comb begin
    u_hit = valid_q[u_idx]
         && (tag_q[u_idx] == u_tag);
    u_ctr = ctr_q[u_idx];
    u_inc = (u_ctr == CMAX) ? u_ctr
          : u_ctr + ctr_t'(1);
    u_dec = (u_ctr == '0) ? u_ctr
          : u_ctr - ctr_t'(1);
  end

  // Wrong direction, or right "taken" to the wrong place.
  assign mispred =
    (bp.upd_taken != bp.upd_pred_taken)
    || (bp.upd_taken && bp.upd_pred_taken
        && (bp.upd_target != bp.upd_pred_target));

  always_comb begin
    cnt_d = cnt_q;
    if (bp.upd_en && mispred && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  assign bp.mispredict_cnt = cnt_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= WN;
      end
    end else begin
      cnt_q <= cnt_d;
      if (bp.clear) begin
        valid_q <= '0;
        for (int i = 0; i < ENTRIES; i++)
          ctr_q[i] <= WN;
      end else if (bp.upd_en) begin
        if (u_hit) begin
          if (bp.upd_taken) begin
            ctr_q[u_idx] <= u_inc;
            tgt_q[u_idx] <= bp.upd_target;
          end else begin
            ctr_q[u_idx] <= u_dec;
          end
        end else if (bp.upd_taken) begin
          valid_q[u_idx] <= 1'b1;
          tag_q[u_idx]   <= u_tag;
          tgt_q[u_idx]   <= bp.upd_target;
          ctr_q[u_idx]   <= WT;
        end
      end
    end
  end

  logic unused_pc_lsb;
  assign unused_pc_lsb = ^{bp.lookup_pc[1:0],
                           bp.upd_pc[1:0]};
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised branch target buffer with saturating direction counters. It replaces the fixed PC+4 / resolve-in-place next-PC selection with a fetch-time prediction. The fetch stage presents its PC and receives a predicted next PC in the same cycle. The execute stage reports each resolved branch or jump one cycle-pulse at a time, and the table learns from those reports. The block also keeps a saturating mispredict counter for performance analysis.

## Interface
- ENTRIES, 16: number of table entries; power of two, >= 2; IDX_W = log2(ENTRIES).
- CTR_W, 2: direction counter width, >= 1.
- CNT_W, 16: mispredict counter width.

- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- lookup_pc  in  32  fetch-stage PC (word_t); bits [1:0] ignored.
- predict_taken  out  1  entry valid, tag match, and counter MSB = 1.
- predict_target  out  32  stored target of the indexed entry; 0 when the entry is invalid.
- pc_next  out  32  predict_taken ? predict_target : lookup_pc + 4.
- upd_en  in  1  one resolved control-flow instruction this cycle; already qualified by stall.
- upd_pc  in  32  PC of the resolved instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual target; valid when upd_taken = 1.
- upd_pred_taken  in  1  predict_taken value carried down the pipe with this instruction.
- upd_pred_target  in  32  predict_target value carried down the pipe with this instruction.
- clear  in  1  synchronous invalidate of all entries.
- mispredict_cnt  out  CNT_W  saturating count of mispredictions.

## Operation
- Address split:
  - index = pc[IDX_W+1:2].
  - tag = pc[31:IDX_W+2].
- Each entry holds valid (1 bit), tag, target (32 bits) and ctr (CTR_W bits). All storage is flops.
- Lookup is purely combinational from lookup_pc and current table state. There is no bypass from a same-cycle update.
- Update (upd_en = 1 and clear = 0), applied at the entry at index(upd_pc):
  - Hit (valid and tag equal), upd_taken = 1: ctr = min(ctr+1, 2^CTR_W-1); target <= upd_target.
  - Hit, upd_taken = 0: ctr = max(ctr-1, 0); target unchanged.
  - Miss, upd_taken = 1: allocate and overwrite any aliasing entry. valid <= 1, tag <= tag(upd_pc), target <= upd_target, ctr <= WT = 2^(CTR_W-1) (weakly taken).
  - Miss, upd_taken = 0: no change to the table.
- clear = 1: all valid <= 0 and all ctr <= WN = 2^(CTR_W-1)-1 (weakly not-taken). Tags and targets are don't-care. If upd_en is high in the same cycle, clear wins for the table.
- Mispredict, evaluated when upd_en = 1 regardless of clear:
  - The instruction is mispredicted when upd_taken != upd_pred_taken, or when upd_taken and upd_pred_taken are both 1 and upd_target != upd_pred_target.
  - Each mispredict increments mispredict_cnt by 1, saturating at 2^CNT_W-1.
- pc_next addition wraps modulo 2^32.

## Timing
- Lookup latency: 0 cycles, combinational from lookup_pc.
- Update latency: the table changes at the CLK edge ending the upd_en cycle and is visible to lookup in the next cycle.
- mispredict_cnt is registered and changes at the same edge as the table.
- Reset (nRST low, asynchronous, takes effect immediately and may occur mid-operation):
  - every valid = 0, every ctr = WN, mispredict_cnt = 0;
  - therefore predict_taken = 0, predict_target = 0, pc_next = lookup_pc + 4;
  - any update in flight is discarded.
- Back-to-back updates to the same entry on consecutive cycles each see the result of the previous update.
- There is no handshake; upd_en is trusted as a single-cycle pulse per resolved instruction.

## Test plan
All scenarios use ENTRIES=16, CTR_W=2, CNT_W=16.
- Reset, then lookup_pc=0x40 -> predict_taken=0, pc_next=0x44, mispredict_cnt=0.
- upd_en, upd_pc=0x40, upd_taken=1, upd_target=0x100, upd_pred_taken=0 -> next cycle lookup 0x40 gives predict_taken=1, pc_next=0x100; mispredict_cnt=1.
- Two not-taken updates at 0x40 with upd_pred_taken matching the then-current prediction -> ctr 10 to 01 (predict 0, cnt +1) then 01 to 00 (predict 0, cnt unchanged).
- Aliasing: entry 0x40 allocated; lookup 0x80 -> predict_taken=0; taken update 0x80 to 0x200 -> lookup 0x80 gives 0x200 and lookup 0x40 gives 0x44.
- Saturation and clear:
  - four taken updates at 0x40 -> ctr=11; one not-taken -> still predict_taken=1;
  - clear with upd_en (taken, pred 0) in the same cycle -> all lookups miss, mispredict_cnt increments.
- Assert nRST mid-sequence between clock edges -> outputs immediately at reset values; the first post-reset lookup of 0x40 misses.
